shiftreg_param: RTL
===================

SHIFTREG_PARAM -- requirements
Module: shiftreg_param

Interface
REQ-001 Parameter: WIDTH, default 8, register length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: enable  input  1  qualifies load and shift; 0 = hold all state.
REQ-005 Port: load  input  1  parallel load request; priority over shift.
REQ-006 Port: direction  input  1  0 = shift left (MSB out first), 1 = shift right (LSB out first).
REQ-007 Port: rotate  input  1  1 = recirculate shifted-out bit as fill (only with macro, REQ-027).
REQ-008 Port: serial_in  input  1  fill bit when not rotating.
REQ-009 Port: parallel_in  input  WIDTH  load data.
REQ-010 Port: out  output  1  registered serial output, last bit shifted out.
REQ-011 Port: parallel_out  output  WIDTH  current register content.
REQ-012 Port: count  output  clog2(WIDTH+1)  bits remaining to shift out.
REQ-013 Port: busy  output  1  combinational, count != 0.
REQ-014 Port: done  output  1  registered one-cycle pulse on final shift of a frame.

Function
REQ-015 Precedence per cycle: reset > enable=0 (hold) > load > shift > idle hold.
REQ-016 enable=0: content, out, count unchanged; done 0 next cycle.
REQ-017 enable=1, load=1: content <= parallel_in, count <= WIDTH, done <= 0, out unchanged; load mid-frame aborts and restarts frame.
REQ-018 enable=1, load=0, count!=0, direction=0: out <= content[WIDTH-1]; content <= {content[WIDTH-2:0], fill}.
REQ-019 enable=1, load=0, count!=0, direction=1: out <= content[0]; content <= {fill, content[WIDTH-1:1]}.
REQ-020 fill = shifted-out bit when rotate=1 (REQ-027), else serial_in.
REQ-021 Each shift: count <= count-1; done <= 1 exactly when count was 1, else 0.
REQ-022 enable=1, load=0, count=0: no shift; content and out hold; done <= 0.
REQ-023 direction and rotate sampled every shift cycle; changing mid-frame legal, takes effect same cycle.
REQ-024 Latency: first serial bit on out one cycle after first shift cycle; parallel_out reflects load one cycle after load.

Reset
REQ-025 reset=1 at rising edge: content 0, out 0, count 0, done 0; overrides enable and load; reset mid-frame discards frame.
REQ-026 No asynchronous path; outputs change only on clk edges (busy follows count).

Configuration
REQ-027 Macro SHIFTREG_PARAM_ROTATE_EN defined: rotate honoured per REQ-020.
REQ-028 Macro undefined: rotate input present but ignored; fill always serial_in; no rotate logic synthesised.

Verification (WIDTH=8)
REQ-029 Reset: drive reset=1 one cycle with load=1 -> parallel_out=0x00, out=0, count=0, done=0, busy=0.
REQ-030 Left shift: load 0xA5, serial_in=0, 8 enabled cycles -> out sequence 1,0,1,0,0,1,0,1; done pulses on 8th shift only; parallel_out=0x00; count=0.
REQ-031 Right shift: load 0xA5, direction=1, serial_in=1 -> out 1,0,1,0,0,1,0,1 (LSB first); final parallel_out=0xFF; 9th enabled cycle: no change, done=0.
REQ-032 Rotate (macro defined): load 0x81, rotate=1, direction=0, 8 shifts -> parallel_out=0x81 again, done pulses once; macro undefined, serial_in=0 -> 0x00.
REQ-033 Hold and abort: load 0xF0, 3 shifts, enable=0 two cycles (count stays 5, out stable), then load 0x0F -> count=8, parallel_out=0x0F, no done pulse.
REQ-034 Reset mid-frame: load 0xFF, 4 shifts, reset=1 -> all outputs zero next cycle; subsequent shifts with count=0 produce no done.

Source files
------------

// File: rtl/shiftreg_param.sv
// -----------------------------------------------------------------------------
// shiftreg_param
//   Parameterised parallel-load / serial-out shift register with a frame
//   counter. A load starts a frame of WIDTH shifts; each enabled cycle while
//   bits remain shifts one bit out (MSB first for left, LSB first for right).
//   `done` pulses on the final shift of a frame.
//
// Configuration macro:
//   SHIFTREG_PARAM_ROTATE_EN  defined   -> rotate=1 recirculates the shifted-out
//                                          bit as the fill bit
//                             undefined -> rotate ignored, fill is serial_in
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   synchronous active-high reset
//   enable        in   qualifies load and shift; 0 holds all state
//   load          in   parallel load request (priority over shift)
//   direction     in   0 = shift left (MSB out), 1 = shift right (LSB out)
//   rotate        in   recirculate shifted-out bit (only with the macro)
//   serial_in     in   fill bit when not rotating
//   parallel_in   in   [WIDTH-1:0] load data
//   out           out  registered serial output, last bit shifted out
//   parallel_out  out  [WIDTH-1:0] current register content
//   count         out  [$clog2(WIDTH+1)-1:0] bits remaining in the frame
//   busy          out  count != 0 (combinational from the count register)
//   done          out  registered one-cycle pulse on final shift of a frame
// -----------------------------------------------------------------------------
module shiftreg_param #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         load,
  input  logic                         direction,
  input  logic                         rotate,
  input  logic                         serial_in,
  input  logic [WIDTH-1:0]             parallel_in,
  output logic                         out,
  output logic [WIDTH-1:0]             parallel_out,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(WIDTH+1);

  logic [WIDTH-1:0] content_q, content_d;
  logic             out_q, out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;

  logic             shift_bit;
  logic             fill;

  // Bit leaving the register this cycle, depending on direction.
  assign shift_bit = direction ? content_q[0] : content_q[WIDTH-1];

`ifdef SHIFTREG_PARAM_ROTATE_EN
  assign fill = rotate ? shift_bit : serial_in;
`else
  // rotate is accepted at the port but has no effect in this build.
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign fill          = serial_in;
`endif

  always_comb begin
    content_d = content_q;
    out_d     = out_q;
    count_d   = count_q;
    done_d    = 1'b0;
    if (enable) begin
      if (load) begin
        // A load mid-frame simply restarts the frame.
        content_d = parallel_in;
        count_d   = CW'(WIDTH);
      end else if (count_q != '0) begin
        out_d   = shift_bit;
        count_d = count_q - 1'b1;
        done_d  = (count_q == CW'(1));
        if (direction) content_d = {fill, content_q[WIDTH-1:1]};
        else           content_d = {content_q[WIDTH-2:0], fill};
      end
    end else begin
      // Hold: done must still drop so it is a single-cycle pulse.
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      content_q <= '0;
      out_q     <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      content_q <= content_d;
      out_q     <= out_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  assign out          = out_q;
  assign parallel_out = content_q;
  assign count        = count_q;
  assign busy         = (count_q != '0);
  assign done         = done_q;

endmodule
